bbs_generator: RTL
==================

# bbs_generator

Parametrised Blum-Blum-Shub pseudo-random generator. It replaces the fixed 16-bit/256-bit counter-plus-multiplier pair with a single sequential core. Modular squaring runs bit-serially, one bit per cycle, so no combinational loop is unrolled. Each squaring harvests K low bits into an OUT_W-bit word, and a start/busy/done handshake plus runtime reseed let the display/button logic fetch successive words.

## Interface
- MW, 16: modulus/state width; MOD < 2^MW.
- MOD, 40633: BBS modulus M (product of two primes ≡ 3 mod 4).
- SEED, 884: default seed, used after reset and for illegal reseeds; 0 < SEED < MOD.
- OUT_W, 256: output word width.
- K, 1: bits harvested per squaring; 1 ≤ K ≤ MW; OUT_W % K == 0.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- start  in  1  level-sampled request to generate one word; honoured only in IDLE.
- reseed  in  1  load seed_in into the state; honoured only in IDLE.
- seed_in  in  MW  new seed value.
- busy  out  1  high while a word is being generated.
- done  out  1  one-cycle pulse when result is updated.
- result  out  OUT_W  last completed word; held stable between done pulses.
- state_x  out  MW  current BBS state x (debug).

## Operation
- N = OUT_W/K squarings per word. Internal registers:
  - x (MW bits)
  - acc (MW+1 bits)
  - bit index i (clog2(MW) bits)
  - squaring count c (clog2(N+1) bits)
  - shift register sh (OUT_W bits)
- FSM states:
  - IDLE: if reseed, load x ← (seed_in == 0 or seed_in ≥ MOD) ? SEED : seed_in. If start, go to SQ with acc=0, i=MW-1, c=0, sh=0. When both are high in the same cycle, the new seed applies to this run (start squares the reseeded value).
  - SQ: one step per cycle, MSB first, all values ≤ 2M-1 within MW+1 bits:
    - acc ← 2·acc; if acc ≥ MOD, acc −= MOD.
    - if x[i], acc += x; if acc ≥ MOD, acc −= MOD.
    - After the i=0 step, go to UPD.
  - UPD: x ← acc; sh ← (sh << K) | acc[K-1:0]; c++.
    - If c+1 == N: result ← the updated sh, done=1, go to IDLE.
    - Else: acc=0, i=MW-1, go to SQ.
- The first harvested bits end up in the MSBs of result.
- x persists across runs; each start continues the sequence. Only reset or reseed restarts it.
- start or reseed while busy: ignored, with no queuing.
- Reset at any time, including mid-run: state→IDLE, x=SEED, result=0, busy=0, done=0, sh=0. The partial word is discarded.

## Timing
- Reset values: busy=0, done=0, result=0, state_x=SEED.
- busy rises at the edge that samples start in IDLE. It falls at the edge that sets done.
- Each squaring takes MW SQ cycles plus 1 UPD cycle.
- Word latency: done is high in the cycle beginning N·(MW+1) edges after the start edge. With defaults this is 256·17 = 4352 cycles.
- done is exactly one cycle wide. result changes only on that edge.
- A start held high continuously is accepted again in the first IDLE cycle after done, giving back-to-back words with one idle cycle.
- Reseed takes effect on the sampling edge; state_x shows the new value the next cycle.

## Test plan
- Reset, then MW=16/MOD=40633/SEED=884, OUT_W=4, K=1; pulse start -> state_x passes 9429, 1037, 18911, 14888; done after 68 cycles; result=4'hE; busy low with done.
- OUT_W=8, K=4, same seed; start -> result=8'h5D after 34 cycles; second start -> result equals golden-model word continuing from x=1037.
- Reseed with seed_in=2, OUT_W=4, K=1, start -> x sequence 4, 16, 256, 24903; result=4'h1. Reseed with seed_in=0 or 50000 -> state_x=884.
- start and reseed together in IDLE with seed_in=2 -> same result as the previous case. Reseed or start pulsed while busy -> no effect on x, result or latency.
- Reset asserted mid-SQ of the 2nd squaring -> busy=0, state_x=884, result=0. A fresh start reproduces the first case exactly.
- Defaults with start held high for 3 words -> done pulses spaced 4353 cycles. Each result matches a software BBS model bit for bit.

Source files
------------

// File: rtl/bbs_generator.sv
// Blum-Blum-Shub pseudo-random word generator with bit-serial modular squaring.
// Each squaring of x harvests K low bits; OUT_W/K squarings form one output word.
module bbs_generator #(
  parameter int unsigned     MW    = 16,
  parameter logic [MW-1:0]   MOD   = MW'(40633),
  parameter logic [MW-1:0]   SEED  = MW'(884),
  parameter int unsigned     OUT_W = 256,
  parameter int unsigned     K     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             reseed,
  input  logic [MW-1:0]    seed_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] result,
  output logic [MW-1:0]    state_x
);

  localparam int unsigned N  = OUT_W / K;
  localparam int unsigned IW = (MW > 1) ? $clog2(MW) : 1;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQ,
    S_UPD
  } state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    x_q, x_d;
  logic [MW:0]      acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d;
  logic [CW-1:0]    c_q, c_d;
  logic [OUT_W-1:0] sh_q, sh_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [MW-1:0]    seed_legal;
  logic [MW:0]      mod_ext, x_ext;
  logic [MW:0]      dbl, dbl_red, add, add_red;
  logic [OUT_W-1:0] harvest, sh_upd;

  // Datapath: acc stays below MOD, so 2*acc and acc+x both fit in MW+1 bits.
  always_comb begin
    seed_legal = (seed_in == '0 || seed_in >= MOD) ? SEED : seed_in;
    mod_ext    = {1'b0, MOD};
    x_ext      = {1'b0, x_q};
    dbl        = acc_q << 1;
    dbl_red    = (dbl >= mod_ext) ? dbl - mod_ext : dbl;
    add        = dbl_red + (x_q[i_q] ? x_ext : '0);
    add_red    = (add >= mod_ext) ? add - mod_ext : add;
    harvest    = '0;
    harvest[K-1:0] = acc_q[K-1:0];
    sh_upd     = (sh_q << K) | harvest;
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d  = state_q;
    x_d      = x_q;
    acc_d    = acc_q;
    i_d      = i_q;
    c_d      = c_q;
    sh_d     = sh_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (reseed) x_d = seed_legal;
        if (start) begin
          state_d = S_SQ;
          acc_d   = '0;
          i_d     = IW'(MW - 1);
          c_d     = '0;
          sh_d    = '0;
          busy_d  = 1'b1;
        end
      end
      S_SQ: begin
        acc_d = add_red;
        i_d   = i_q - IW'(1);
        if (i_q == '0) state_d = S_UPD;
      end
      S_UPD: begin
        x_d  = acc_q[MW-1:0];
        sh_d = sh_upd;
        c_d  = c_q + CW'(1);
        if (c_q == CW'(N - 1)) begin
          result_d = sh_upd;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          acc_d   = '0;
          i_d     = IW'(MW - 1);
          state_d = S_SQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= SEED;
      acc_q    <= '0;
      i_q      <= '0;
      c_q      <= '0;
      sh_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      c_q      <= c_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign state_x = x_q;

endmodule
